// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: one-outstanding imem reads, registered IF/ID slot, one-entry skid buffer
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_IFID,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic take;
    logic req;
    logic accept;

    // The slot may be overwritten when it is empty or IF/ID is advancing.
    assign take   = !valid_q || !stall;
    assign req    = !flush_IFID &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_WAIT) && imem_rvalid && take));
    assign accept = req && imem_ready;

    assign imem_req    = req;
    assign imem_addr   = fetch_pc_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign fetch_valid = valid_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (flush_IFID) begin
            valid_d      = 1'b0;
            pc_d         = 32'h0;
            instr_d      = 32'h0;
            hold_pc_d    = 32'h0;
            hold_instr_d = 32'h0;
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            // A response still in flight must be swallowed before refetching.
            case (state_q)
                ST_WAIT:  state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        valid_d = 1'b0;
                        pc_d    = 32'h0;
                        instr_d = 32'h0;
                    end
                    if (accept) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (take) begin
                            valid_d = 1'b1;
                            pc_d    = req_pc_q;
                            instr_d = imem_rdata;
                            state_d = accept ? ST_WAIT : ST_IDLE;
                        end else begin
                            hold_pc_d    = req_pc_q;
                            hold_instr_d = imem_rdata;
                            state_d      = ST_HOLD;
                        end
                    end else if (take) begin
                        valid_d = 1'b0;
                        pc_d    = 32'h0;
                        instr_d = 32'h0;
                    end
                end
                ST_HOLD: begin
                    if (take) begin
                        valid_d = 1'b1;
                        pc_d    = hold_pc_q;
                        instr_d = hold_instr_q;
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    valid_d = 1'b0;
                    pc_d    = 32'h0;
                    instr_d = 32'h0;
                    if (imem_rvalid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC_ALIGNED;
            req_pc_q     <= 32'h0;
            valid_q      <= 1'b0;
            pc_q         <= 32'h0;
            instr_q      <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush_IFID;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush_IFID  (flush_IFID),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .Instruction (Instruction),
        .fetch_valid (fetch_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model: one outstanding read, data = address + 0x0100_0000.
    bit          pend;
    int          cnt;
    int          lat;
    logic [31:0] paddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req && imem_ready && reset;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (imem_rvalid) pend = 1'b0;
        if (pend && cnt > 0) cnt--;
        if (acc) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = a;
        end
        imem_rvalid = pend && (cnt == 0);
        imem_rdata  = imem_rvalid ? paddr + 32'h0100_0000 : 32'h0;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, {31'h0, fetch_valid}, {31'h0, v});
        check({tag, "_pc"}, PC, pc);
        check({tag, "_instr"}, Instruction, ins);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        flush_IFID  = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        cnt         = 0;
        lat         = 1;
        paddr       = 32'h0;

        repeat (3) cycle();
        check_slot("reset", 1'b0, 32'h0, 32'h0);

        // Streaming fetch, 1-cycle memory
        reset      = 1'b1;
        imem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("stream_req", {31'h0, imem_req}, 32'h1);
            check("stream_addr", imem_addr, 32'(4 * k));
            cycle();
            if (k == 0) check_slot("stream_first", 1'b0, 32'h0, 32'h0);
            else check_slot("stream", 1'b1, 32'(4 * (k - 1)), 32'(4 * (k - 1)) + 32'h0100_0000);
        end

        // Stall for 3 cycles while the response for 0x14 returns
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall_req", {31'h0, imem_req}, 32'h0);
            cycle();
            check_slot("stall_frozen", 1'b1, 32'h10, 32'h0100_0010);
        end
        stall = 1'b0;
        settle();
        check("hold_req", {31'h0, imem_req}, 32'h0);
        cycle();
        check_slot("hold_out", 1'b1, 32'h14, 32'h0100_0014);
        settle();
        check("after_hold_addr", imem_addr, 32'h18);
        check("after_hold_req", {31'h0, imem_req}, 32'h1);
        cycle();
        check_slot("after_hold_bubble", 1'b0, 32'h0, 32'h0);
        settle();
        check("next_addr", imem_addr, 32'h1C);
        lat = 3;
        cycle();
        check_slot("next_out", 1'b1, 32'h18, 32'h0100_0018);

        // Flush while waiting on a 3-cycle read; low address bits ignored
        settle();
        check("wait_req", {31'h0, imem_req}, 32'h0);
        cycle();
        check_slot("wait_bubble", 1'b0, 32'h0, 32'h0);
        flush_IFID  = 1'b1;
        redirect_pc = 32'h103;
        settle();
        check("flush_req", {31'h0, imem_req}, 32'h0);
        cycle();
        flush_IFID = 1'b0;
        check_slot("flush_slot", 1'b0, 32'h0, 32'h0);
        settle();
        check("drain_req", {31'h0, imem_req}, 32'h0);
        cycle();
        check_slot("drain_slot", 1'b0, 32'h0, 32'h0);
        lat = 1;
        settle();
        check("redir_req", {31'h0, imem_req}, 32'h1);
        check("redir_addr", imem_addr, 32'h100);
        cycle();
        check_slot("redir_bubble", 1'b0, 32'h0, 32'h0);
        settle();
        check("redir_next_addr", imem_addr, 32'h104);
        cycle();
        check_slot("redir_out", 1'b1, 32'h100, 32'h0100_0100);

        // Flush and stall together with a full slot: flush wins
        flush_IFID  = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h200;
        settle();
        check("flstall_req", {31'h0, imem_req}, 32'h0);
        cycle();
        flush_IFID = 1'b0;
        stall      = 1'b0;
        check_slot("flstall_slot", 1'b0, 32'h0, 32'h0);
        settle();
        check("flstall_addr", imem_addr, 32'h200);
        check("flstall_req2", {31'h0, imem_req}, 32'h1);
        cycle();
        settle();
        check("flstall_addr2", imem_addr, 32'h204);
        cycle();
        check_slot("flstall_out", 1'b1, 32'h200, 32'h0100_0200);

        // imem_ready low for 4 cycles
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("nrdy_req", {31'h0, imem_req}, 32'h1);
            check("nrdy_addr", imem_addr, 32'h208);
            cycle();
            if (k == 0) check_slot("nrdy_first", 1'b1, 32'h204, 32'h0100_0204);
            else check_slot("nrdy_bubble", 1'b0, 32'h0, 32'h0);
        end
        imem_ready = 1'b1;
        settle();
        check("rdy_addr", imem_addr, 32'h208);
        cycle();
        check_slot("rdy_bubble", 1'b0, 32'h0, 32'h0);
        lat = 3;
        settle();
        check("rdy_next_addr", imem_addr, 32'h20C);
        cycle();
        check_slot("rdy_out", 1'b1, 32'h208, 32'h0100_0208);

        // Reset mid-WAIT with a full, stalled slot; late response after release
        stall = 1'b1;
        settle();
        check("prerst_req", {31'h0, imem_req}, 32'h0);
        check_slot("prerst", 1'b1, 32'h208, 32'h0100_0208);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check_slot("async_rst", 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();
        reset = 1'b1;
        lat   = 1;
        settle();
        check("late_rvalid_present", {31'h0, imem_rvalid}, 32'h1);
        check("rst_req", {31'h0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, 32'h0);
        cycle();
        check_slot("late_ignored", 1'b0, 32'h0, 32'h0);
        settle();
        check("rst_next_addr", imem_addr, 32'h4);
        cycle();
        check_slot("rst_first_out", 1'b1, 32'h0, 32'h0100_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the `PC`/`Instruction` pair latched by the IF/ID pipeline register. It keeps the fetch PC and issues one-outstanding-request reads to instruction memory over a ready/valid handshake. It obeys the same `stall` and `flush` controls the IF/ID register sees, and holds a one-entry skid buffer so no fetched instruction is lost under stall. Empty cycles are presented as bubbles (`Instruction` = 0, i.e. `sll $0,$0,0`).

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  IF/ID holds this cycle; the presented slot must not change.
- `flush_IFID`  in  1  taken branch/jump; same signal that clears IF/ID. Priority over `stall`.
- `redirect_pc`  in  32  target address, valid when `flush_IFID`=1.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  read address, word-aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; exactly one per accepted request, ≥1 cycle after acceptance.
- `imem_rdata`  in  32  read data.
- `PC`  out  32  PC of presented instruction (to IF/ID `PC` input).
- `Instruction`  out  32  presented instruction (to IF/ID `Instruction` input).
- `fetch_valid`  out  1  presented slot holds a real instruction.

## Operation
- Registers: `fetch_pc`, `req_pc`, output slot {`fetch_valid`,`PC`,`Instruction`}, hold buffer {`hold_pc`,`hold_instr`}, state.
- States: IDLE (no request outstanding), WAIT (request outstanding), HOLD (response parked in hold buffer), DRAIN (outstanding response must be discarded).
- `take` = `!fetch_valid || !stall`: the slot may be overwritten this cycle.
- `imem_req` = !`flush_IFID` && ((IDLE) || (WAIT && `imem_rvalid` && `take`)); `imem_addr` = `fetch_pc`.
- Request accepted (`imem_req` && `imem_ready`): `req_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc`+4 (wraps mod 2^32), next state WAIT.
- IDLE: if `take`, the slot is cleared (`fetch_valid`=0, `PC`=0, `Instruction`=0). Otherwise it holds.
- WAIT, `imem_rvalid`, `take`: slot ← {1, `req_pc`, `imem_rdata`}. Next state is WAIT if a new request is accepted the same cycle, else IDLE.
- WAIT, `imem_rvalid`, !`take`: hold ← {`req_pc`, `imem_rdata`}, → HOLD. No request is issued.
- WAIT, no `imem_rvalid`: if `take`, the slot is cleared.
- HOLD: when `take`, slot ← hold and state → IDLE. Otherwise stay.
- DRAIN: `imem_req`=0. The slot is kept clear. On `imem_rvalid` the data is discarded and state → IDLE.
- `flush_IFID` (any state, regardless of `stall`):
  - slot cleared, `fetch_pc` ← `redirect_pc`, hold buffer discarded;
  - WAIT without `imem_rvalid` this cycle → DRAIN;
  - WAIT with `imem_rvalid`, or IDLE/HOLD → IDLE;
  - DRAIN stays DRAIN unless `imem_rvalid` → IDLE.
- `redirect_pc`[1:0] are ignored (forced 0).
- Order is preserved: the hold buffer always reaches the slot before any newer response.

## Timing
- Reset (async assert, sync release): state IDLE, `fetch_pc`=`RESET_PC`, `PC`=0, `Instruction`=0, `fetch_valid`=0, hold cleared.
- `imem_req`=1 with `imem_addr`=`RESET_PC` in the first cycle after release.
- Slot outputs are registered. Response data appears on `Instruction` the cycle after `imem_rvalid`.
- With `imem_ready`=1 and 1-cycle read latency, throughput is one instruction per cycle after a 2-cycle initial latency.
- Redirect penalty with 1-cycle memory: the first redirected instruction is presented 2 cycles after the `flush_IFID` cycle.
- Reset asserted mid-WAIT/HOLD: all state drops immediately. A late `imem_rvalid` after release while in IDLE is ignored.

## Test plan
- Reset release, `imem_ready`=1, rdata = addr: `imem_addr` 0,4,8,… on consecutive cycles. `PC`/`Instruction` = 0/0, 4/4, 8/8 from cycle 2, `fetch_valid`=1.
- `stall` held 3 cycles while a response returns: slot frozen, response parked in HOLD, no request issued. On release, slot shows the parked instruction, then the next address; no skips, no duplicates.
- `flush_IFID` with `redirect_pc`=32'h100 while in WAIT (3-cycle memory): stale response discarded in DRAIN, next `imem_addr`=32'h100, slot shows 0 until `PC`=32'h100 appears.
- `flush_IFID` and `stall` both 1 with a full slot: slot cleared to 0 and `fetch_pc`=`redirect_pc` (flush wins).
- `imem_ready` low for 4 cycles: `imem_req` and `imem_addr` stay stable, bubbles (`Instruction`=0, `fetch_valid`=0) presented.
- `reset` pulsed low mid-WAIT: outputs 0 immediately. After release the first request is to `RESET_PC`, and the late `imem_rvalid` is ignored.
